// File: rtl/dp_noise_pkg.sv
// rtl/dp_noise_pkg.sv - shared state encoding and default constants for the DP noise path
package dp_noise_pkg;

  typedef enum logic [1:0] {
    SIGN  = 2'd0,
    TRIAL = 2'd1,
    HOLD  = 2'd2
  } geo_state_t;

  localparam int DEF_UW      = 8;
  localparam int DEF_THRESH  = 128;
  localparam int DEF_MAG_W   = 8;
  localparam int DEF_MAG_MAX = 255;

endpackage

// File: rtl/rand_word_packer.sv
// rtl/rand_word_packer.sv - serial-to-parallel packer turning the keystream into UW-bit trial words
module rand_word_packer
  import dp_noise_pkg::*;
#(
  parameter int UW = DEF_UW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          rand_bit,
  output logic [UW-1:0] word,
  output logic          word_done
);

  localparam int CW = (UW > 1) ? $clog2(UW) : 1;

  // Only UW-1 history bits are kept; the newest bit completes the word combinationally.
  logic [UW-2:0] shreg;
  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
    end else if (en) begin
      shreg   <= (UW-1)'({shreg, rand_bit});
      bit_cnt <= (bit_cnt == CW'(UW-1)) ? '0 : bit_cnt + 1'b1;
    end
  end

  assign word      = {shreg, rand_bit};
  assign word_done = en && (bit_cnt == CW'(UW-1));

endmodule

// File: rtl/dp_geo_noise.sv
// rtl/dp_geo_noise.sv - two-sided geometric noise sampler fed by a 1-bit keystream
module dp_geo_noise
  import dp_noise_pkg::*;
#(
  parameter int UW      = DEF_UW,
  parameter int THRESH  = DEF_THRESH,
  parameter int MAG_W   = DEF_MAG_W,
  parameter int MAG_MAX = DEF_MAG_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rand_bit,
  output logic [MAG_W:0] noise_out,
  output logic           noise_valid,
  input  logic           noise_ready,
  output logic           reject_pulse
);

  geo_state_t       state;
  logic             sign;
  logic [MAG_W-1:0] mag;
  logic [UW-1:0]    word;
  logic             word_done;
  logic             word_lt;
  logic             mag_top;
  logic [MAG_W-1:0] stop_mag;
  logic [MAG_W:0]   stop_ext;
  logic [MAG_W:0]   sample;

  rand_word_packer #(.UW(UW)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state == TRIAL),
    .clr       (state != TRIAL),
    .rand_bit  (rand_bit),
    .word      (word),
    .word_done (word_done)
  );

  // A continue trial that would reach MAG_MAX ends the sample right there,
  // so saturated samples never need a trailing stop word.
  always_comb begin
    word_lt  = ({1'b0, word} < (UW+1)'(THRESH));
    mag_top  = (mag >= MAG_W'(MAG_MAX - 1));
    stop_mag = word_lt ? MAG_W'(MAG_MAX) : mag;
    stop_ext = {1'b0, stop_mag};
    sample   = sign ? (~stop_ext + 1'b1) : stop_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SIGN;
      sign         <= 1'b0;
      mag          <= '0;
      noise_out    <= '0;
      noise_valid  <= 1'b0;
      reject_pulse <= 1'b0;
    end else begin
      reject_pulse <= 1'b0;
      case (state)
        SIGN: begin
          sign  <= rand_bit;
          mag   <= '0;
          state <= TRIAL;
        end
        TRIAL: begin
          if (word_done) begin
            if (word_lt && !mag_top) begin
              mag <= mag + 1'b1;
            end else if (!word_lt && (mag == '0) && sign) begin
              // -0 would double the weight of zero; draw a fresh sign instead.
              reject_pulse <= 1'b1;
              state        <= SIGN;
            end else begin
              mag         <= stop_mag;
              noise_out   <= sample;
              noise_valid <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (noise_valid && noise_ready) begin
            noise_valid <= 1'b0;
            state       <= SIGN;
          end
        end
        default: state <= SIGN;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_geo_noise.sv
// tb/tb_dp_geo_noise.sv - self-checking bench for dp_geo_noise against a stream-level model
module tb_dp_geo_noise;

  localparam int UW     = 4;
  localparam int THRESH = 8;
  localparam int MAG_W  = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rand_bit = 1'b0;
  logic           noise_ready = 1'b1;
  logic [MAG_W:0] noise_out, noise_out_s;
  logic           noise_valid, noise_valid_s;
  logic           reject_pulse, reject_pulse_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dp_geo_noise #(.UW(UW), .THRESH(THRESH), .MAG_W(MAG_W), .MAG_MAX(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rand_bit     (rand_bit),
    .noise_out    (noise_out),
    .noise_valid  (noise_valid),
    .noise_ready  (noise_ready),
    .reject_pulse (reject_pulse)
  );

  dp_geo_noise #(.UW(UW), .THRESH(THRESH), .MAG_W(MAG_W), .MAG_MAX(3)) dut_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .rand_bit     (rand_bit),
    .noise_out    (noise_out_s),
    .noise_valid  (noise_valid_s),
    .noise_ready  (noise_ready),
    .reject_pulse (reject_pulse_s)
  );

  // Reference: walk the bit stream trial by trial and report the sample value,
  // the number of bits consumed until it is presented, and the rejects on the way.
  function automatic void model(input bit q[$], input int mag_max,
                                output int val, output int cyc, output int nrej);
    int  i;
    int  m;
    int  w;
    bit  sgn;
    bit  done;
    bit  rej;
    i = 0; val = 0; cyc = -1; nrej = 0;
    while (i < q.size()) begin
      sgn = q[i];
      i++;
      m = 0; done = 0; rej = 0;
      while (!done && !rej) begin
        if (i + UW > q.size()) return;
        w = 0;
        for (int k = 0; k < UW; k++) w = w * 2 + int'(q[i + k]);
        i += UW;
        if (w < THRESH) begin
          if (m + 1 >= mag_max) begin m = mag_max; done = 1; end
          else m++;
        end else if (m == 0 && sgn) begin
          rej = 1;
        end else begin
          done = 1;
        end
      end
      if (done) begin
        val = sgn ? -m : m;
        cyc = i;
        return;
      end
      nrej++;
    end
  endfunction

  task automatic tick(input bit b);
    rand_bit = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed(input bit q[$], output int fv, output logic [MAG_W:0] fval,
                      output int fr, output int nr, output int fvs, output logic [MAG_W:0] fvals);
    fv = -1; fr = -1; nr = 0; fvs = -1; fval = '0; fvals = '0;
    for (int i = 0; i < q.size(); i++) begin
      tick(q[i]);
      if (noise_valid && fv < 0) begin fv = i + 1; fval = noise_out; end
      if (reject_pulse) begin nr++; if (fr < 0) fr = i + 1; end
      if (noise_valid_s && fvs < 0) begin fvs = i + 1; fvals = noise_out_s; end
    end
  endtask

  task automatic gen(output bit q[$], output int cyc, output logic [MAG_W:0] e, output int nrej);
    int v;
    do begin
      q = {};
      for (int i = 0; i < 300; i++) q.push_back(bit'($urandom_range(0, 1)));
      model(q, 255, v, cyc, nrej);
    end while (cyc < 0);
    while (q.size() > cyc) void'(q.pop_back());
    e = v[MAG_W:0];
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (noise_valid !== 1'b0 || noise_out !== '0 || reject_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b out=%h rej=%b required 0/000/0", noise_valid, noise_out, reject_pulse);
    end
    checks++;
    if (noise_valid_s !== 1'b0 || noise_out_s !== '0 || reject_pulse_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat: valid=%b out=%h rej=%b required 0/000/0", noise_valid_s, noise_out_s, reject_pulse_s);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    bit q[$];
    int fv, fr, nr, fvs;
    logic [MAG_W:0] fval, fvals;
    do_reset();
    noise_ready = 1'b1;
    q = '{0, 1, 1, 1, 1};
    feed(q, fv, fval, fr, nr, fvs, fvals);
    checks++;
    if (fv !== 5 || fval !== 9'h000) begin
      errors++;
      $display("FAIL zero: valid_at=%0d out=%h required 5/000", fv, fval);
    end
    tick(bit'($urandom_range(0, 1)));
    checks++;
    if (noise_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_handshake: valid=%b required 0", noise_valid);
    end
  endtask

  task automatic test_negative();
    bit q[$];
    int fv, fr, nr, fvs;
    logic [MAG_W:0] fval, fvals;
    do_reset();
    q = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    feed(q, fv, fval, fr, nr, fvs, fvals);
    checks++;
    if (fv !== 9 || fval !== 9'h1FF) begin
      errors++;
      $display("FAIL negative: valid_at=%0d out=%h required 9/1ff", fv, fval);
    end
  endtask

  task automatic test_reject();
    bit q[$];
    int fv, fr, nr, fvs;
    logic [MAG_W:0] fval, fvals;
    do_reset();
    q = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    feed(q, fv, fval, fr, nr, fvs, fvals);
    checks++;
    if (fr !== 5 || nr !== 1) begin
      errors++;
      $display("FAIL reject_pulse: first_at=%0d count=%0d required 5/1", fr, nr);
    end
    checks++;
    if (fv !== 14 || fval !== 9'h001) begin
      errors++;
      $display("FAIL reject_then_pos: valid_at=%0d out=%h required 14/001", fv, fval);
    end
  endtask

  task automatic test_saturate();
    bit q[$];
    int fv, fr, nr, fvs;
    logic [MAG_W:0] fval, fvals;
    do_reset();
    q = {};
    for (int i = 0; i < 13; i++) q.push_back(1'b0);
    feed(q, fv, fval, fr, nr, fvs, fvals);
    checks++;
    if (fvs !== 13 || fvals !== 9'h003) begin
      errors++;
      $display("FAIL saturate: valid_at=%0d out=%h required 13/003", fvs, fvals);
    end
    checks++;
    if (fv !== -1) begin
      errors++;
      $display("FAIL saturate_unsat_dut: valid_at=%0d required none", fv);
    end
  endtask

  task automatic test_backpressure();
    bit q[$];
    int fv, fr, nr, fvs, cyc, erej;
    logic [MAG_W:0] fval, fvals, e;
    do_reset();
    noise_ready = 1'b0;
    gen(q, cyc, e, erej);
    feed(q, fv, fval, fr, nr, fvs, fvals);
    checks++;
    if (fv !== cyc || fval !== e) begin
      errors++;
      $display("FAIL bp_sample: valid_at=%0d out=%h required %0d/%h", fv, fval, cyc, e);
    end
    for (int i = 0; i < 10; i++) begin
      tick(bit'($urandom_range(0, 1)));
      checks++;
      if (noise_valid !== 1'b1 || noise_out !== e) begin
        errors++;
        $display("FAIL bp_hold: cycle=%0d valid=%b out=%h required 1/%h", i, noise_valid, noise_out, e);
      end
    end
    noise_ready = 1'b1;
    tick(bit'($urandom_range(0, 1)));
    checks++;
    if (noise_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: valid=%b required 0", noise_valid);
    end
    gen(q, cyc, e, erej);
    feed(q, fv, fval, fr, nr, fvs, fvals);
    checks++;
    if (fv !== cyc || fval !== e) begin
      errors++;
      $display("FAIL bp_next: valid_at=%0d out=%h required %0d/%h", fv, fval, cyc, e);
    end
  endtask

  task automatic test_async_reset();
    bit q[$];
    int fv, fr, nr, fvs, cyc, erej;
    logic [MAG_W:0] fval, fvals, e;
    do_reset();
    noise_ready = 1'b1;
    q = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    feed(q, fv, fval, fr, nr, fvs, fvals);
    tick(1'b0);
    q = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    feed(q, fv, fval, fr, nr, fvs, fvals);
    checks++;
    if (fv !== -1) begin
      errors++;
      $display("FAIL async_pre: valid_at=%0d required none", fv);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (noise_out !== '0 || noise_valid !== 1'b0 || reject_pulse !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: out=%h valid=%b rej=%b required 000/0/0", noise_out, noise_valid, reject_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    gen(q, cyc, e, erej);
    feed(q, fv, fval, fr, nr, fvs, fvals);
    checks++;
    if (fv !== cyc || fval !== e || nr !== erej) begin
      errors++;
      $display("FAIL async_after: valid_at=%0d out=%h rej=%0d required %0d/%h/%0d", fv, fval, nr, cyc, e, erej);
    end
  endtask

  task automatic test_back_to_back();
    bit q[$];
    int fv, fr, nr, fvs, cyc, erej, stalls;
    logic [MAG_W:0] fval, fvals, e;
    do_reset();
    noise_ready = 1'b1;
    for (int s = 0; s < 30; s++) begin
      gen(q, cyc, e, erej);
      feed(q, fv, fval, fr, nr, fvs, fvals);
      checks++;
      if (fv !== cyc || fval !== e || nr !== erej) begin
        errors++;
        $display("FAIL b2b_sample: n=%0d valid_at=%0d out=%h rej=%0d required %0d/%h/%0d",
                 s, fv, fval, nr, cyc, e, erej);
      end
      stalls = $urandom_range(0, 3);
      noise_ready = (stalls == 0);
      for (int i = 0; i < stalls; i++) begin
        tick(bit'($urandom_range(0, 1)));
        checks++;
        if (noise_valid !== 1'b1 || noise_out !== e) begin
          errors++;
          $display("FAIL b2b_stall: n=%0d valid=%b out=%h required 1/%h", s, noise_valid, noise_out, e);
        end
      end
      noise_ready = 1'b1;
      tick(bit'($urandom_range(0, 1)));
      checks++;
      if (noise_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_handshake: n=%0d valid=%b required 0", s, noise_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_negative();
    test_reject();
    test_saturate();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
